// File: rtl/bp_gselect_sched.sv
// bp_gselect_sched: gselect predictor scheduler owning the PHT, speculative/architectural GHRs and the in-flight queue.
// Defining BP_STATS_EN adds the correct_count and stall_count statistics outputs.
module bp_gselect_sched #(
  parameter int PC_BITS  = 2,
  parameter int GHR_BITS = 2,
  parameter int PC_W     = 8,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       lk_valid,
  input  logic [PC_W-1:0]            lk_pc,
  output logic                       lk_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output logic [$clog2(DEPTH)-1:0]   pred_tag,
  input  logic                       rs_valid,
  input  logic                       rs_taken,
  output logic                       rs_ready,
  input  logic                       flush,
  output logic                       recover,
  output logic [CNT_W-1:0]           mispredict_count,
  output logic [$clog2(DEPTH):0]     inflight
`ifdef BP_STATS_EN
  ,
  output logic [CNT_W-1:0]           correct_count,
  output logic [CNT_W-1:0]           stall_count
`endif
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int IDX_W = PC_BITS + GHR_BITS;
  localparam int N     = 1 << IDX_W;

  logic [1:0]          pht_q [N];
  logic [1:0]          pht_d [N];
  logic [IDX_W-1:0]    q_idx_q [DEPTH];
  logic [IDX_W-1:0]    q_idx_d [DEPTH];
  logic [DEPTH-1:0]    q_pred_q, q_pred_d;
  logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d, arch_ghr_q, arch_ghr_d;
  logic [TAG_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pred_tag_q, pred_tag_d;
  logic [TAG_W:0]      count_q, count_d;
  logic                pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d, recover_q, recover_d;
  logic [CNT_W-1:0]    mis_cnt_q, mis_cnt_d;
  logic                lk_fire, rs_fire, mispred, clear, lk_pred, head_pred;
  logic [IDX_W-1:0]    lk_idx, head_idx;
  logic [1:0]          head_cnt, upd_cnt;
  logic                unused_pc;

  assign unused_pc = ^lk_pc;
  // Any presented resolve stalls lookup so lk_ready never depends on queue occupancy through rs_ready.
  assign lk_ready  = (count_q != (TAG_W+1)'(DEPTH)) && !rs_valid && !flush;
  assign rs_ready  = count_q != '0;
  assign lk_fire   = lk_valid && lk_ready;
  assign rs_fire   = rs_valid && rs_ready;
  assign lk_idx    = {lk_pc[PC_BITS-1:0], spec_ghr_q};
  assign lk_pred   = pht_q[lk_idx][1];
  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_pred = q_pred_q[rd_ptr_q];
  assign head_cnt  = pht_q[head_idx];
  assign upd_cnt   = rs_taken ? (&head_cnt ? head_cnt : head_cnt + 2'd1)
                              : (|head_cnt ? head_cnt - 2'd1 : head_cnt);
  assign mispred   = rs_fire && (head_pred != rs_taken);
  assign clear     = mispred || flush;

  always_comb begin
    pht_d    = pht_q;
    q_idx_d  = q_idx_q;
    q_pred_d = q_pred_q;
    if (rs_fire) pht_d[head_idx] = upd_cnt;
    if (lk_fire) begin
      q_idx_d[wr_ptr_q]  = lk_idx;
      q_pred_d[wr_ptr_q] = lk_pred;
    end
    arch_ghr_d   = rs_fire ? {arch_ghr_q[GHR_BITS-2:0], rs_taken} : arch_ghr_q;
    spec_ghr_d   = clear   ? arch_ghr_d
                 : lk_fire ? {spec_ghr_q[GHR_BITS-2:0], lk_pred} : spec_ghr_q;
    wr_ptr_d     = clear ? '0 : lk_fire ? wr_ptr_q + TAG_W'(1) : wr_ptr_q;
    rd_ptr_d     = clear ? '0 : rs_fire ? rd_ptr_q + TAG_W'(1) : rd_ptr_q;
    count_d      = clear ? '0 : count_q + (TAG_W+1)'(lk_fire) - (TAG_W+1)'(rs_fire);
    pred_valid_d = lk_fire;
    pred_taken_d = lk_fire && lk_pred;
    pred_tag_d   = lk_fire ? wr_ptr_q : pred_tag_q;
    recover_d    = mispred;
    mis_cnt_d    = (mispred && !(&mis_cnt_q)) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < DEPTH; i++) q_idx_q[i] <= '0;
      q_pred_q     <= '0;
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_tag_q   <= '0;
      recover_q    <= 1'b0;
      mis_cnt_q    <= '0;
    end else begin
      pht_q        <= pht_d;
      q_idx_q      <= q_idx_d;
      q_pred_q     <= q_pred_d;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_tag_q   <= pred_tag_d;
      recover_q    <= recover_d;
      mis_cnt_q    <= mis_cnt_d;
    end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_tag         = pred_tag_q;
  assign recover          = recover_q;
  assign mispredict_count = mis_cnt_q;
  assign inflight         = count_q;

`ifdef BP_STATS_EN
  logic [CNT_W-1:0] correct_count_q, correct_count_d, stall_count_q, stall_count_d;

  always_comb begin
    correct_count_d = (rs_fire && !mispred && !(&correct_count_q)) ? correct_count_q + CNT_W'(1) : correct_count_q;
    stall_count_d   = (lk_valid && !lk_ready && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      correct_count_q <= '0;
      stall_count_q   <= '0;
    end else begin
      correct_count_q <= correct_count_d;
      stall_count_q   <= stall_count_d;
    end

  assign correct_count = correct_count_q;
  assign stall_count   = stall_count_q;
`endif
endmodule

// File: tb/tb_bp_gselect_sched.sv
// tb_bp_gselect_sched: directed vector table plus randomized traffic checked against a transaction-level predictor model.
module tb_bp_gselect_sched;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lk_valid = 1'b0, rs_valid = 1'b0, rs_taken = 1'b0, flush = 1'b0;
  logic [7:0] lk_pc = '0;
  logic       lk_ready, pred_valid, pred_taken, rs_ready, recover;
  logic [1:0] pred_tag;
  logic [3:0] mispredict_count;
  logic [2:0] inflight;

  bp_gselect_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag),
    .rs_valid(rs_valid), .rs_taken(rs_taken), .rs_ready(rs_ready), .flush(flush),
    .recover(recover), .mispredict_count(mispredict_count), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int pred; } ent_t;
  typedef struct { bit lv; int pc; bit rv, rt, fl; bit lkr, pv, pt; int tag, infl; bit rec; int cnt; } vec_t;

  int   checks = 0, errors = 0;
  int   pht [16];
  int   sghr, aghr, wp, mcnt, e_pv, e_pt, e_tag, e_rec, last_lkr;
  ent_t q [$];
  vec_t vt [35];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pht[i] = 1;
    sghr = 0; aghr = 0; wp = 0; mcnt = 0;
    e_pv = 0; e_pt = 0; e_tag = 0; e_rec = 0;
    q.delete();
  endtask

  task automatic cyc(input bit lv, input int pc, input bit rv, input bit rt, input bit fl);
    int lkr, idx;
    bit lf, rf;
    ent_t e;
    lk_valid = lv; lk_pc = pc[7:0]; rs_valid = rv; rs_taken = rt; flush = fl;
    #1;
    lkr = (q.size() < DEPTH && !rv && !fl) ? 1 : 0;
    last_lkr = int'(lk_ready);
    chk("lk_ready", int'(lk_ready), lkr);
    chk("rs_ready", int'(rs_ready), q.size() > 0 ? 1 : 0);
    @(posedge clk);
    lf = lv && lkr != 0;
    rf = rv && q.size() > 0;
    e_pv = 0; e_rec = 0;
    if (lf) begin
      idx = (pc % 4) * 4 + sghr;
      e.idx = idx; e.pred = pht[idx] >= 2 ? 1 : 0;
      q.push_back(e);
      e_pv = 1; e_pt = e.pred; e_tag = wp;
      wp = (wp + 1) % DEPTH;
      sghr = ((sghr << 1) | e.pred) & 3;
    end
    if (rf) begin
      e = q.pop_front();
      pht[e.idx] = rt ? (pht[e.idx] == 3 ? 3 : pht[e.idx] + 1) : (pht[e.idx] == 0 ? 0 : pht[e.idx] - 1);
      aghr = ((aghr << 1) | rt) & 3;
      if (e.pred != int'(rt)) begin
        e_rec = 1;
        mcnt = mcnt == 15 ? 15 : mcnt + 1;
        q.delete(); wp = 0; sghr = aghr;
      end
    end
    if (fl) begin
      q.delete(); wp = 0; sghr = aghr;
    end
    #1;
    chk("pred_valid", int'(pred_valid), e_pv);
    chk("recover", int'(recover), e_rec);
    chk("mispredict_count", int'(mispredict_count), mcnt);
    chk("inflight", int'(inflight), q.size());
    if (e_pv != 0) begin
      chk("pred_taken", int'(pred_taken), e_pt);
      chk("pred_tag", int'(pred_tag), e_tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1,0,0,0,0, 1,1,0,0,1,0,0};
    vt[1]  = '{1,0,0,0,0, 1,1,0,1,2,0,0};
    vt[2]  = '{1,0,0,0,0, 1,1,0,2,3,0,0};
    vt[3]  = '{1,0,0,0,0, 1,1,0,3,4,0,0};
    vt[4]  = '{1,0,0,0,0, 0,0,0,0,4,0,0};
    vt[5]  = '{1,0,1,0,0, 0,0,0,0,3,0,0};
    vt[6]  = '{1,0,0,0,0, 1,1,0,0,4,0,0};
    vt[7]  = '{0,0,1,0,0, 0,0,0,0,3,0,0};
    vt[8]  = '{0,0,1,0,0, 0,0,0,0,2,0,0};
    vt[9]  = '{0,0,1,0,0, 0,0,0,0,1,0,0};
    vt[10] = '{0,0,1,0,0, 0,0,0,0,0,0,0};
    vt[11] = '{1,0,1,0,0, 0,0,0,0,0,0,0};
    vt[12] = '{1,1,0,0,0, 1,1,0,1,1,0,0};
    vt[13] = '{0,0,1,1,0, 0,0,0,0,0,1,1};
    vt[14] = '{1,2,0,0,0, 1,1,0,0,1,0,1};
    vt[15] = '{0,0,1,0,0, 0,0,0,0,0,0,1};
    vt[16] = '{1,2,0,0,0, 1,1,0,1,1,0,1};
    vt[17] = '{0,0,1,0,0, 0,0,0,0,0,0,1};
    vt[18] = '{1,1,0,0,0, 1,1,1,2,1,0,1};
    vt[19] = '{0,0,1,1,0, 0,0,0,0,0,0,1};
    vt[20] = '{1,2,0,0,0, 1,1,0,3,1,0,1};
    vt[21] = '{0,0,1,0,0, 0,0,0,0,0,0,1};
    vt[22] = '{1,2,0,0,0, 1,1,0,0,1,0,1};
    vt[23] = '{0,0,1,0,0, 0,0,0,0,0,0,1};
    vt[24] = '{1,1,0,0,0, 1,1,1,1,1,0,1};
    vt[25] = '{0,0,1,1,0, 0,0,0,0,0,0,1};
    vt[26] = '{1,3,0,0,0, 1,1,0,2,1,0,1};
    vt[27] = '{1,3,0,0,0, 1,1,0,3,2,0,1};
    vt[28] = '{1,3,0,0,0, 1,1,0,0,3,0,1};
    vt[29] = '{0,0,1,1,0, 0,0,0,0,0,1,2};
    vt[30] = '{0,0,1,0,0, 0,0,0,0,0,0,2};
    vt[31] = '{1,0,0,0,0, 1,1,0,0,1,0,2};
    vt[32] = '{0,0,1,0,1, 0,0,0,0,0,0,2};
    vt[33] = '{1,0,0,0,0, 1,1,0,0,1,0,2};
    vt[34] = '{0,0,1,0,0, 0,0,0,0,0,0,2};

    model_reset();
    #12;
    chk("rst_pred_valid", int'(pred_valid), 0);
    chk("rst_pred_taken", int'(pred_taken), 0);
    chk("rst_pred_tag", int'(pred_tag), 0);
    chk("rst_recover", int'(recover), 0);
    chk("rst_mispredict_count", int'(mispredict_count), 0);
    chk("rst_inflight", int'(inflight), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      cyc(vt[i].lv, vt[i].pc, vt[i].rv, vt[i].rt, vt[i].fl);
      chk($sformatf("vec%0d_lk_ready", i), last_lkr, int'(vt[i].lkr));
      chk($sformatf("vec%0d_pred_valid", i), int'(pred_valid), int'(vt[i].pv));
      chk($sformatf("vec%0d_inflight", i), int'(inflight), vt[i].infl);
      chk($sformatf("vec%0d_recover", i), int'(recover), int'(vt[i].rec));
      chk($sformatf("vec%0d_mis_count", i), int'(mispredict_count), vt[i].cnt);
      if (vt[i].pv) begin
        chk($sformatf("vec%0d_pred_taken", i), int'(pred_taken), int'(vt[i].pt));
        chk($sformatf("vec%0d_pred_tag", i), int'(pred_tag), vt[i].tag);
      end
    end

    for (int i = 0; i < 15; i++) begin
      cyc(1, int'($urandom_range(0, 255)), 0, 0, 0);
      cyc(0, 0, 1, e_pt == 0, 0);
    end
    chk("mis_saturated", int'(mispredict_count), 15);
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, e_pt == 0, 0);
    chk("mis_stays_saturated", int'(mispredict_count), 15);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);

    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    #2;
    lk_valid = 0; rs_valid = 0; flush = 0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pred_valid", int'(pred_valid), 0);
    chk("midrst_inflight", int'(inflight), 0);
    chk("midrst_mispredict_count", int'(mispredict_count), 0);
    chk("midrst_recover", int'(recover), 0);
    chk("midrst_rs_ready", int'(rs_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("postrst_pred_taken", int'(pred_taken), 0);
    chk("postrst_pred_tag", int'(pred_tag), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
